// File: rtl/grey_hot_monitor.sv
// Checker for the grey-code / one-hot counter stage: decodes each sampled grey
// count, verifies single-step advance and one-hot rotation, and tracks lock.
module grey_hot_monitor #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned HOT_W     = 8,
    parameter int unsigned ERR_W     = 8,
    parameter int unsigned LOCK_N    = 4,
    parameter bit          CHECK_HOT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] grey_in,
    input  logic [HOT_W-1:0] hot_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             locked,
    output logic             grey_err,
    output logic             hot_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   good_cnt_q, good_cnt_d;
    logic [WIDTH-1:0]   bin_out_q, bin_out_d;
    logic [HOT_W-1:0]   prev_hot_q, prev_hot_d;
    logic               locked_q, locked_d;
    logic               grey_err_q, grey_err_d;
    logic               hot_err_q, hot_err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]   bin_dec;
    logic [HOT_W-1:0]   hot_rot;
    logic               hot_one;
    logic               grey_ok;
    logic               hot_ok;
    logic               sample_ok;

    // bin_out_q doubles as the previous decoded sample
    always_comb begin
        bin_dec = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bin_dec[i] = ^(grey_in >> i);
        end
        hot_rot   = (prev_hot_q << 1) | (prev_hot_q >> (HOT_W - 1));
        hot_one   = (hot_in != '0) && ((hot_in & (hot_in - HOT_W'(1))) == '0);
        grey_ok   = (bin_dec == (bin_out_q + WIDTH'(1)));
        hot_ok    = CHECK_HOT ? (hot_one && (hot_in == hot_rot)) : 1'b1;
        sample_ok = grey_ok && hot_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEEK;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        if (en) begin
            case (state_q)
                SEEK: begin
                    state_d    = ACQ;
                    good_cnt_d = '0;
                end
                ACQ: begin
                    if (!sample_ok) begin
                        good_cnt_d = '0;
                    end else if (CNT_W'(good_cnt_q + CNT_W'(1)) == CNT_W'(LOCK_N)) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = CNT_W'(good_cnt_q + CNT_W'(1));
                    end
                end
                LOCKED: begin
                    if (!sample_ok) begin
                        state_d    = ACQ;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = SEEK;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    // Error pulses and counting only apply to samples judged while locked
    always_comb begin
        bin_out_d  = bin_out_q;
        prev_hot_d = prev_hot_q;
        locked_d   = (state_d == LOCKED);
        grey_err_d = 1'b0;
        hot_err_d  = 1'b0;
        err_cnt_d  = err_cnt_q;
        if (en) begin
            bin_out_d  = bin_dec;
            prev_hot_d = hot_in;
            if (state_q == LOCKED && !sample_ok) begin
                grey_err_d = !grey_ok;
                hot_err_d  = !hot_ok;
                if (err_cnt_q != '1) begin
                    err_cnt_d = ERR_W'(err_cnt_q + ERR_W'(1));
                end
            end
        end
        if (clr_err) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_out_q  <= '0;
            prev_hot_q <= '0;
            locked_q   <= 1'b0;
            grey_err_q <= 1'b0;
            hot_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            bin_out_q  <= bin_out_d;
            prev_hot_q <= prev_hot_d;
            locked_q   <= locked_d;
            grey_err_q <= grey_err_d;
            hot_err_q  <= hot_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bin_out  = bin_out_q;
    assign locked   = locked_q;
    assign grey_err = grey_err_q;
    assign hot_err  = hot_err_q;
    assign err_cnt  = err_cnt_q;

endmodule
